// File: rtl/merget_pulse_merger.sv
// Confluence buffer for toggle-encoded SFQ pulse streams: merges pulses on a/b onto q
// with coincidence absorption, per-input timing checks, output spacing and a pending buffer.
module merget_pulse_merger #(
    parameter int unsigned DELAY     = 2,
    parameter int unsigned CT_IN     = 3,
    parameter int unsigned CT_OUT    = 2,
    parameter int unsigned MERGE_WIN = 1,
    parameter int unsigned DEPTH     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic q,
    output logic busy,
    output logic err_ct,
    output logic err_ovf
);

    localparam int unsigned CT_IN_LD  = (CT_IN > 1) ? CT_IN - 1 : 0;
    localparam int unsigned CT_OUT_LD = (CT_OUT > 1) ? CT_OUT - 1 : 0;
    localparam int unsigned CT_IN_W   = (CT_IN_LD > 0) ? $clog2(CT_IN_LD + 1) : 1;
    localparam int unsigned CT_OUT_W  = (CT_OUT_LD > 0) ? $clog2(CT_OUT_LD + 1) : 1;
    localparam int unsigned WIN_W     = (MERGE_WIN > 0) ? $clog2(MERGE_WIN + 1) : 1;
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1);

    logic                armed;
    logic                a_prev;
    logic                b_prev;
    logic [CT_IN_W-1:0]  ct_a;
    logic [CT_IN_W-1:0]  ct_b;
    logic [WIN_W-1:0]    win;
    logic [DELAY-1:0]    dl;
    logic [CNT_W-1:0]    cnt;
    logic [CT_OUT_W-1:0] gap;

    logic                edge_a;
    logic                edge_b;
    logic                acc_a;
    logic                acc_b;
    logic                ev;
    logic                arrive;
    logic                emit;
    logic                drop;
    logic [CT_IN_W-1:0]  ct_a_n;
    logic [CT_IN_W-1:0]  ct_b_n;
    logic [WIN_W-1:0]    win_n;
    logic [DELAY-1:0]    dl_n;
    logic [CNT_W-1:0]    cnt_n;
    logic [CT_OUT_W-1:0] gap_n;
    logic                q_n;
    logic                err_ct_n;
    logic                err_ovf_n;

    // Detection, timing checks, merging, buffering and emission for the next edge
    always_comb begin
        edge_a    = armed & (a ^ a_prev);
        edge_b    = armed & (b ^ b_prev);
        acc_a     = edge_a & (ct_a == '0);
        acc_b     = edge_b & (ct_b == '0);
        // Coincident edges always merge; a lone edge inside the window is absorbed
        ev        = (acc_a & acc_b) | ((acc_a ^ acc_b) & (win == '0));
        arrive    = dl[DELAY-1];
        emit      = (cnt != '0) && (gap == '0);
        drop      = arrive && (cnt == CNT_W'(DEPTH)) && !emit;

        ct_a_n    = ct_a;
        ct_b_n    = ct_b;
        win_n     = win;
        gap_n     = gap;
        cnt_n     = cnt;
        dl_n      = (dl << 1) | DELAY'(ev);
        q_n       = q ^ emit;
        err_ct_n  = err_ct | (edge_a & ~acc_a) | (edge_b & ~acc_b);
        err_ovf_n = err_ovf | drop;

        if (acc_a) begin
            ct_a_n = CT_IN_W'(CT_IN_LD);
        end else if (ct_a != '0) begin
            ct_a_n = ct_a - CT_IN_W'(1);
        end

        if (acc_b) begin
            ct_b_n = CT_IN_W'(CT_IN_LD);
        end else if (ct_b != '0) begin
            ct_b_n = ct_b - CT_IN_W'(1);
        end

        if (ev) begin
            win_n = WIN_W'(MERGE_WIN);
        end else if (win != '0) begin
            win_n = win - WIN_W'(1);
        end

        if (emit) begin
            gap_n = CT_OUT_W'(CT_OUT_LD);
        end else if (gap != '0) begin
            gap_n = gap - CT_OUT_W'(1);
        end

        case ({arrive & ~drop, emit})
            2'b10:   cnt_n = cnt + CNT_W'(1);
            2'b01:   cnt_n = cnt - CNT_W'(1);
            default: cnt_n = cnt;
        endcase
    end

    // State registers; the first edge after reset only captures the input levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed   <= 1'b0;
            a_prev  <= 1'b0;
            b_prev  <= 1'b0;
            ct_a    <= '0;
            ct_b    <= '0;
            win     <= '0;
            dl      <= '0;
            cnt     <= '0;
            gap     <= '0;
            q       <= 1'b0;
            err_ct  <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            armed   <= 1'b1;
            a_prev  <= a;
            b_prev  <= b;
            ct_a    <= ct_a_n;
            ct_b    <= ct_b_n;
            win     <= win_n;
            dl      <= dl_n;
            cnt     <= cnt_n;
            gap     <= gap_n;
            q       <= q_n;
            err_ct  <= err_ct_n;
            err_ovf <= err_ovf_n;
        end
    end

    assign busy = (cnt != '0) || (|dl);

endmodule
